// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: FSM states, opcodes,
// ALU encodings and the control-vector struct driven by the output decoder.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, HALT, ERROR
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       busy;
        logic       halted;
        logic       error;
    } ctrl_t;

    // The halt word is matched before the opcode so ECALL never reaches ERROR.
    function automatic state_t decode_target(input logic [31:0] instr,
                                             input logic [31:0] halt_instr);
        state_t nxt;
        if (instr == halt_instr) begin
            nxt = HALT;
        end else begin
            case (instr[6:0])
                OP_R:               nxt = EXEC_R;
                OP_I:               nxt = EXEC_I;
                OP_LOAD, OP_STORE:  nxt = MEM_ADDR;
                OP_BRANCH:          nxt = BRANCH;
                default:            nxt = ERROR;
            endcase
        end
        return nxt;
    endfunction

    function automatic logic retires(input state_t state, input logic mem_ready);
        return (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
               ((state == MEM_WR) && mem_ready);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller, the slave side is the datapath that consumes the enables.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             pc_source;
    logic             busy;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instr, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               busy, halted, error, retired
    );

    modport slave (
        output run, instr, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               busy, halted, error, retired
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// State -> control-vector decoder. Only the fetch-complete strobes look at
// mem_ready; everything else is a pure function of the state register.
module ctrl_outdec
    import rv_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl      = '0;
        ctrl.busy = !((state == IDLE) || (state == HALT) || (state == ERROR));
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            WB_ALU: ctrl.reg_write = 1'b1;
            WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RS2;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
            end
            HALT:    ctrl.halted = 1'b1;
            ERROR:   ctrl.error  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// with ready-handshaked memory and counts retired instructions.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.master bus
);
    state_t           state_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;
    ctrl_t            ctrl;

    assign retire = retires(state_reg, bus.mem_ready);

    // Retirement overrides the per-state transition; run is only consulted
    // at instruction boundaries so dropping it never aborts an instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                IDLE:           if (bus.run) state_reg <= FETCH;
                FETCH:          if (bus.mem_ready) state_reg <= DECODE;
                DECODE:         state_reg <= decode_target(bus.instr, HALT_INSTR);
                EXEC_R, EXEC_I: state_reg <= WB_ALU;
                MEM_ADDR:       state_reg <= (bus.instr[6:0] == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD:         if (bus.mem_ready) state_reg <= WB_MEM;
                default:        ;
            endcase
            if (retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
                state_reg   <= bus.run ? FETCH : IDLE;
            end
        end
    end

    ctrl_outdec u_outdec (
        .state     (state_reg),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.iord          = ctrl.iord;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.busy          = ctrl.busy;
    assign bus.halted        = ctrl.halted;
    assign bus.error         = ctrl.error;
    assign bus.retired       = retired_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a directed per-cycle vector table, hand-written
// corner sequences, and a randomized run against an instruction-level model.
module tb_multicycle_ctrl;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.CNT_W(32), .HALT_INSTR(32'h0000_0073)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [31:0] R_INS  = 32'h002081B3;
    localparam logic [31:0] I_INS  = 32'h00500093;
    localparam logic [31:0] LW_INS = 32'h0040A183;
    localparam logic [31:0] SW_INS = 32'h0020A223;
    localparam logic [31:0] BQ_INS = 32'h00208463;
    localparam logic [31:0] EC_INS = 32'h00000073;
    localparam logic [31:0] IL_INS = 32'h0000007F;

    typedef struct {
        logic        run;
        logic [31:0] instr;
        logic        rdy;
        logic [16:0] exp;
        logic [31:0] ret;
        string       name;
    } vec_t;
    vec_t tbl[$];

    logic [16:0] V_IDLE, V_FETCH, V_FETCHW, V_DEC, V_EXR, V_EXI, V_MA;
    logic [16:0] V_MRD, V_MWR, V_WBA, V_WBM, V_BR, V_HALT, V_ERR;

    function automatic logic [16:0] vec(input logic pcw, pwc, irw, mr, mw, io, rw, m2r, asa,
                                        input logic [1:0] asb, aop,
                                        input logic pcs, bsy, hl, er);
        return {pcw, pwc, irw, mr, mw, io, rw, m2r, asa, asb, aop, pcs, bsy, hl, er};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.iord, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.busy, bus.halted, bus.error};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] ins, input logic rdy,
                       input logic [16:0] exp, input logic [31:0] ret, input string nm);
        vec_t v;
        v.run = r; v.instr = ins; v.rdy = rdy; v.exp = exp; v.ret = ret; v.name = nm;
        tbl.push_back(v);
    endtask

    // One clock cycle: drive just after the edge, sample mid-cycle, advance.
    task automatic step(input logic r, input logic [31:0] ins, input logic rdy,
                        input logic [16:0] exp, input logic [31:0] ret, input string nm);
        bus.run = r; bus.instr = ins; bus.mem_ready = rdy;
        #3;
        check({nm, "_ctrl"}, 64'(obs()), 64'(exp));
        check({nm, "_retired"}, 64'(bus.retired), 64'(ret));
        $display("cycle %-18s run=%0b rdy=%0b ctrl=%h retired=%0d", nm, r, rdy, obs(), bus.retired);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.run = 1'b0; bus.instr = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Instruction-level reference: each instruction is a list of phases; access
    // phases repeat while mem_ready is low, the last phase retires it.
    localparam int PH_F = 0, PH_P = 1, PH_RD = 2, PH_WR = 3, PH_WB = 4, PH_WBM = 5, PH_BR = 6;
    int          plan[$];
    logic [31:0] cur;

    task automatic new_instr();
        int cls;
        cls = $urandom_range(0, 4);
        cur = $urandom;
        case (cls)
            0: begin cur[6:0] = 7'b0110011; plan = '{PH_F, PH_P, PH_P, PH_WB}; end
            1: begin cur[6:0] = 7'b0010011; plan = '{PH_F, PH_P, PH_P, PH_WB}; end
            2: begin cur[6:0] = 7'b0000011; plan = '{PH_F, PH_P, PH_P, PH_RD, PH_WBM}; end
            3: begin cur[6:0] = 7'b0100011; plan = '{PH_F, PH_P, PH_P, PH_WR}; end
            default: begin cur[6:0] = 7'b1100011; plan = '{PH_F, PH_P, PH_BR}; end
        endcase
    endtask

    task automatic random_run(input int cycles);
        bit          idle;
        int          pi;
        int          ph;
        int          mret;
        logic        r, rdy;
        logic [8:0]  exp9, act9;
        idle = 1'b1; pi = 0; mret = 0; cur = '0;
        for (int c = 0; c < cycles; c++) begin
            r   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            bus.run = r; bus.mem_ready = rdy; bus.instr = cur;
            #3;
            ph = idle ? -1 : plan[pi];
            if (idle) exp9 = '0;
            else exp9 = {(ph == PH_F) && rdy, ph == PH_BR, (ph == PH_F) && rdy,
                         (ph == PH_F) || (ph == PH_RD), ph == PH_WR,
                         (ph == PH_RD) || (ph == PH_WR), (ph == PH_WB) || (ph == PH_WBM),
                         ph == PH_WBM, 1'b1};
            act9 = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                    bus.iord, bus.reg_write, bus.mem_to_reg, bus.busy};
            check("rand_ctrl", 64'(act9), 64'(exp9));
            check("rand_retired", 64'(bus.retired), 64'(mret));
            if (idle) begin
                if (r) begin idle = 1'b0; new_instr(); pi = 0; end
            end else if (((ph == PH_F) || (ph == PH_RD) || (ph == PH_WR)) && !rdy) begin
                // waiting on memory
            end else if (pi == plan.size() - 1) begin
                mret++;
                $display("retire #%0d instr=%h", mret, cur);
                if (r) begin new_instr(); pi = 0; end
                else idle = 1'b1;
            end else begin
                pi++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        V_IDLE   = '0;
        V_FETCH  = vec(1,0,1,1,0,0,0,0,0,2'b01,2'b00,0,1,0,0);
        V_FETCHW = vec(0,0,0,1,0,0,0,0,0,2'b01,2'b00,0,1,0,0);
        V_DEC    = vec(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0,1,0,0);
        V_EXR    = vec(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,1,0,0);
        V_EXI    = vec(0,0,0,0,0,0,0,0,1,2'b10,2'b10,0,1,0,0);
        V_MA     = vec(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,1,0,0);
        V_MRD    = vec(0,0,0,1,0,1,0,0,0,2'b00,2'b00,0,1,0,0);
        V_MWR    = vec(0,0,0,0,1,1,0,0,0,2'b00,2'b00,0,1,0,0);
        V_WBA    = vec(0,0,0,0,0,0,1,0,0,2'b00,2'b00,0,1,0,0);
        V_WBM    = vec(0,0,0,0,0,0,1,1,0,2'b00,2'b00,0,1,0,0);
        V_BR     = vec(0,1,0,0,0,0,0,0,1,2'b00,2'b01,1,1,0,0);
        V_HALT   = vec(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,0);
        V_ERR    = vec(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,1);

        // Back-to-back R, load (3 waits), I, store (fetch wait), branch with run drop.
        add(1, R_INS,  1, V_IDLE,   0, "idle_go");
        add(1, R_INS,  1, V_FETCH,  0, "r_fetch");
        add(1, R_INS,  1, V_DEC,    0, "r_dec");
        add(1, R_INS,  1, V_EXR,    0, "r_exec");
        add(1, R_INS,  1, V_WBA,    0, "r_wb");
        add(1, LW_INS, 1, V_FETCH,  1, "lw_fetch");
        add(1, LW_INS, 1, V_DEC,    1, "lw_dec");
        add(1, LW_INS, 1, V_MA,     1, "lw_addr");
        add(1, LW_INS, 0, V_MRD,    1, "lw_wait1");
        add(1, LW_INS, 0, V_MRD,    1, "lw_wait2");
        add(1, LW_INS, 0, V_MRD,    1, "lw_wait3");
        add(1, LW_INS, 1, V_MRD,    1, "lw_rd");
        add(1, LW_INS, 1, V_WBM,    1, "lw_wb");
        add(1, I_INS,  1, V_FETCH,  2, "i_fetch");
        add(1, I_INS,  1, V_DEC,    2, "i_dec");
        add(1, I_INS,  1, V_EXI,    2, "i_exec");
        add(1, I_INS,  1, V_WBA,    2, "i_wb");
        add(1, SW_INS, 0, V_FETCHW, 3, "sw_fetch_wait");
        add(1, SW_INS, 1, V_FETCH,  3, "sw_fetch");
        add(1, SW_INS, 1, V_DEC,    3, "sw_dec");
        add(1, SW_INS, 1, V_MA,     3, "sw_addr");
        add(1, SW_INS, 1, V_MWR,    3, "sw_wr");
        add(1, BQ_INS, 1, V_FETCH,  4, "beq_fetch");
        add(1, BQ_INS, 1, V_DEC,    4, "beq_dec");
        add(0, BQ_INS, 1, V_BR,     4, "beq_br");
        add(0, BQ_INS, 1, V_IDLE,   5, "beq_idle1");
        add(0, BQ_INS, 1, V_IDLE,   5, "beq_idle2");

        do_reset();
        for (int i = 0; i < 5; i++) step(0, R_INS, 1, V_IDLE, 0, "reset_idle");
        foreach (tbl[i]) step(tbl[i].run, tbl[i].instr, tbl[i].rdy, tbl[i].exp, tbl[i].ret, tbl[i].name);

        // ECALL: halts without retiring and ignores run afterwards.
        step(1, EC_INS, 1, V_IDLE,  5, "halt_go");
        step(1, EC_INS, 1, V_FETCH, 5, "halt_fetch");
        step(1, EC_INS, 1, V_DEC,   5, "halt_dec");
        for (int i = 0; i < 3; i++) step(1, EC_INS, 1, V_HALT, 5, "halt_sticky");

        // Illegal opcode: ERROR is sticky.
        do_reset();
        step(1, IL_INS, 1, V_IDLE,  0, "ill_go");
        step(1, IL_INS, 1, V_FETCH, 0, "ill_fetch");
        step(1, IL_INS, 1, V_DEC,   0, "ill_dec");
        for (int i = 0; i < 10; i++) step(1, IL_INS, 1, V_ERR, 0, "ill_sticky");

        // Reset while a store is waiting on memory.
        do_reset();
        step(1, SW_INS, 1, V_IDLE,  0, "rst_go");
        step(1, SW_INS, 1, V_FETCH, 0, "rst_fetch");
        step(1, SW_INS, 1, V_DEC,   0, "rst_dec");
        step(1, SW_INS, 1, V_MA,    0, "rst_addr");
        step(1, SW_INS, 0, V_MWR,   0, "rst_wait");
        reset = 1'b1;
        step(1, SW_INS, 0, V_MWR,   0, "rst_edge");
        reset = 1'b0;
        step(0, SW_INS, 0, V_IDLE,  0, "rst_idle");

        // Run dropped mid-instruction: the instruction still completes.
        step(1, R_INS, 1, V_IDLE,  0, "drop_go");
        step(1, R_INS, 1, V_FETCH, 0, "drop_fetch");
        step(1, R_INS, 1, V_DEC,   0, "drop_dec");
        step(0, R_INS, 1, V_EXR,   0, "drop_exec");
        step(0, R_INS, 1, V_WBA,   0, "drop_wb");
        step(0, R_INS, 1, V_IDLE,  1, "drop_idle");

        do_reset();
        random_run(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
